// File: rtl/serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
// Shared definitions for the serial frame transmitter:
//   tx_state_e  - frame FSM states
//   LINE_IDLE   - line level while idle / during stop bits (mark)
//   LINE_START  - line level of the start bit (space)
//   parity_bit  - parity of a data word, even or odd
// -----------------------------------------------------------------------------
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Widest data word the transmitter supports; narrower words are
  // zero-extended before the parity reduction, which leaves the result
  // unchanged.
  localparam int MAX_DATA_W = 16;

  // Even parity makes the total count of ones (data + parity) even.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic                  odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Down-counter that defines the duration of one serial bit.
// Ports:
//   clk     in  - clock, rising edge
//   reset_n in  - synchronous active-low reset (counter -> 0)
//   load    in  - restart the bit period (frame acceptance)
//   tick    out - high in the final clock of each bit period
// -----------------------------------------------------------------------------
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Reaching zero is itself a bit boundary, so the counter reloads there
  // without any help from the FSM. With CLKS_PER_BIT=1 it simply stays at 0
  // and tick is high every clock.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
// Frames parallel words as asynchronous serial frames:
//   start bit, DATA_W data bits, optional parity bit, 1 or 2 stop bits.
// Ports:
//   clk        in           - clock, rising edge
//   reset_n    in           - synchronous active-low reset
//   tx_data    in  [DATA_W] - word to send, sampled on acceptance only
//   tx_valid   in           - a word is offered
//   tx_ready   out          - word can be accepted (state IDLE)
//   serial_out out          - registered line output, idle high
//   busy       out          - frame in progress
//   done       out          - one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  localparam int BIT_CNT_W = $clog2(DATA_W);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_e             r_state;
  tx_state_e             w_state_next;
  logic [DATA_W-1:0]     r_shift;
  logic                  r_parity;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_serial_out;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_tick;
  logic                  w_cur_bit;
  logic                  w_line;

  assign w_accept  = tx_valid && (r_state == IDLE);
  assign w_cur_bit = (MSB_FIRST != 0) ? r_shift[DATA_W-1] : r_shift[0];

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_accept),
    .tick    (w_tick)
  );

  // Next state and the line level belonging to the current state. The line
  // level is registered below, so the line trails the state by one clock.
  always_comb begin
    w_state_next = r_state;
    w_line       = LINE_IDLE;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = START;
      end
      START: begin
        w_line = LINE_START;
        if (w_tick) w_state_next = DATA;
      end
      DATA: begin
        w_line = w_cur_bit;
        if (w_tick && (r_bit_cnt == LAST_DATA)) begin
          w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        w_line = r_parity;
        if (w_tick) w_state_next = STOP;
      end
      STOP: begin
        w_line = LINE_IDLE;
        if (w_tick && (r_bit_cnt == LAST_STOP)) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_bit_cnt    <= '0;
      r_serial_out <= LINE_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_serial_out <= w_line;
      // busy and done are aligned with the registered line rather than the
      // state: busy covers exactly the frame's line cycles, and done fires
      // on the first cycle the line is back in idle.
      r_busy       <= (r_state != IDLE);
      r_done       <= r_busy && (r_state == IDLE);

      if (w_accept) begin
        r_shift   <= tx_data;
        r_parity  <= parity_bit(MAX_DATA_W'(tx_data), (PARITY_ODD != 0));
        r_bit_cnt <= '0;
      end else if (w_tick) begin
        case (r_state)
          DATA: begin
            r_shift <= (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                        : {1'b0, r_shift[DATA_W-1:1]};
            // The data counter is reused to count stop bits, so it wraps
            // to zero on the last data bit.
            r_bit_cnt <= (r_bit_cnt == LAST_DATA) ? '0 : r_bit_cnt + 1'b1;
          end
          STOP: begin
            r_bit_cnt <= (r_bit_cnt == LAST_STOP) ? '0 : r_bit_cnt + 1'b1;
          end
          default: begin
            r_bit_cnt <= r_bit_cnt;
          end
        endcase
      end
    end
  end

  assign tx_ready   = (r_state == IDLE);
  assign serial_out = r_serial_out;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
